// File: rtl/udp_parser_pkg.sv
// Shared types for the UDP receive stage: header layout, parser states and field widths.
package udp_parser_pkg;

  localparam int unsigned UDP_HDR_LEN = 8;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned PORT_W      = 16;
  localparam int unsigned HDR_FIELD_W = 3 * PORT_W;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [PORT_W-1:0] port_t;

  // First six header bytes as they arrive on the wire (big-endian)
  typedef struct packed {
    port_t             src;
    port_t             dst;
    logic [PORT_W-1:0] len;
  } udp_hdr_t;

  typedef enum logic [1:0] {
    UDP_HDR,
    UDP_PAYLOAD,
    UDP_DROP
  } udp_state_t;

endpackage

// File: rtl/udp_parser.sv
// Strips the UDP header from the IP payload stream, filters on destination port and
// forwards payload bytes, trimming IP padding and flagging bad or aborted datagrams.
module udp_parser
  import udp_parser_pkg::*;
#(
  parameter port_t UDP_PORT = 16'd5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  byte_t             ip_data_in,
  input  logic              ip_byte_valid,
  input  logic              ip_eof,
  input  logic              ip_err,
  output byte_t             udp_data_out,
  output logic              udp_byte_valid,
  output logic              udp_eof,
  output logic              udp_err,
  output port_t             udp_src_port,
  output logic [PORT_W-1:0] udp_payload_len
);

  udp_state_t        state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  udp_hdr_t          hdr_q, hdr_d;
  logic [PORT_W-1:0] pay_cnt_q, pay_cnt_d;
  port_t             src_q, src_d;
  logic [PORT_W-1:0] len_q, len_d;
  byte_t             data_q, data_d;
  logic              valid_q, valid_d;
  logic              eof_q, eof_d;
  logic              err_q, err_d;

  logic              hdr_done;
  logic              hdr_good;
  logic              pay_fwd;
  logic [PORT_W-1:0] pay_cnt_nxt;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
    pay_cnt_d = pay_cnt_q;
    src_d     = src_q;
    len_d     = len_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;

    hdr_done    = (state_q == UDP_HDR) && ip_byte_valid && (hdr_cnt_q == 3'd7);
    hdr_good    = (hdr_q.dst == UDP_PORT) && (hdr_q.len >= PORT_W'(UDP_HDR_LEN));
    pay_fwd     = (state_q == UDP_PAYLOAD) && ip_byte_valid && (pay_cnt_q < len_q);
    pay_cnt_nxt = pay_fwd ? pay_cnt_q + 16'd1 : pay_cnt_q;

    case (state_q)
      UDP_HDR: begin
        if (ip_byte_valid) begin
          // Checksum bytes 6-7 are never shifted in, so byte 7 sees src/dst/len intact
          if (hdr_cnt_q < 3'd6) begin
            hdr_d = {hdr_q[HDR_FIELD_W-BYTE_W-1:0], ip_data_in};
          end
          if (hdr_done) begin
            hdr_cnt_d = '0;
            if (hdr_good) begin
              state_d   = UDP_PAYLOAD;
              src_d     = hdr_q.src;
              len_d     = hdr_q.len - PORT_W'(UDP_HDR_LEN);
              pay_cnt_d = '0;
            end else begin
              state_d = UDP_DROP;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      UDP_PAYLOAD: begin
        if (pay_fwd) begin
          data_d    = ip_data_in;
          valid_d   = 1'b1;
          pay_cnt_d = pay_cnt_nxt;
        end
      end
      default: ;
    endcase

    // Abort outranks end-of-frame; a coincident byte is thrown away
    if (ip_err) begin
      data_d    = data_q;
      valid_d   = 1'b0;
      src_d     = src_q;
      len_d     = len_q;
      err_d     = !((state_q == UDP_HDR) && (hdr_cnt_q == 3'd0));
      state_d   = UDP_HDR;
      hdr_cnt_d = '0;
      pay_cnt_d = '0;
    end else if (ip_eof) begin
      state_d   = UDP_HDR;
      hdr_cnt_d = '0;
      pay_cnt_d = '0;
      case (state_q)
        UDP_HDR: begin
          if (hdr_done && hdr_good && (hdr_q.len == PORT_W'(UDP_HDR_LEN))) begin
            eof_d = 1'b1;
          end else if ((hdr_cnt_q != 3'd0) || ip_byte_valid) begin
            err_d = 1'b1;
          end
        end
        UDP_PAYLOAD: begin
          if (pay_cnt_nxt == len_q) begin
            eof_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UDP_HDR;
      hdr_cnt_q <= '0;
      hdr_q     <= '0;
      pay_cnt_q <= '0;
      src_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      hdr_q     <= hdr_d;
      pay_cnt_q <= pay_cnt_d;
      src_q     <= src_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
    end
  end

  assign udp_data_out    = data_q;
  assign udp_byte_valid  = valid_q;
  assign udp_eof         = eof_q;
  assign udp_err         = err_q;
  assign udp_src_port    = src_q;
  assign udp_payload_len = len_q;

endmodule

// File: tb/tb_udp_parser.sv
// Directed bench for udp_parser: paced datagrams with random payloads, checked against
// expectations derived from the header fields each scenario builds.
module tb_udp_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ip_data_in;
  logic        ip_byte_valid;
  logic        ip_eof;
  logic        ip_err;
  logic [7:0]  udp_data_out;
  logic        udp_byte_valid;
  logic        udp_eof;
  logic        udp_err;
  logic [15:0] udp_src_port;
  logic [15:0] udp_payload_len;

  int errors = 0;
  int checks = 0;

  logic [7:0] frm[$];
  logic [7:0] pay[$];
  logic [7:0] out_q[$];
  int         n_eof = 0;
  int         n_err = 0;
  logic       eof_with_byte = 1'b0;

  int base_out, base_eof, base_err;

  udp_parser #(.UDP_PORT(16'd5000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ip_data_in      (ip_data_in),
    .ip_byte_valid   (ip_byte_valid),
    .ip_eof          (ip_eof),
    .ip_err          (ip_err),
    .udp_data_out    (udp_data_out),
    .udp_byte_valid  (udp_byte_valid),
    .udp_eof         (udp_eof),
    .udp_err         (udp_err),
    .udp_src_port    (udp_src_port),
    .udp_payload_len (udp_payload_len)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (udp_byte_valid) out_q.push_back(udp_data_out);
      if (udp_eof) begin
        n_eof         <= n_eof + 1;
        eof_with_byte <= udp_byte_valid;
      end
      if (udp_err) n_err <= n_err + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ip_byte_valid = 1'b0;
      ip_eof        = 1'b0;
      ip_err        = 1'b0;
    end
  endtask

  task automatic mark();
    base_out = out_q.size();
    base_eof = n_eof;
    base_err = n_err;
  endtask

  task automatic build(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input int npay);
    logic [7:0] b;
    frm.delete();
    pay.delete();
    frm.push_back(src[15:8]);
    frm.push_back(src[7:0]);
    frm.push_back(dst[15:8]);
    frm.push_back(dst[7:0]);
    frm.push_back(len[15:8]);
    frm.push_back(len[7:0]);
    frm.push_back(8'($urandom));
    frm.push_back(8'($urandom));
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      frm.push_back(b);
    end
  endtask

  // mode 0: eof on last byte, 1: standalone eof, 2: no eof, 3: err+eof on last byte
  task automatic send(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ip_data_in    = frm[i];
      ip_byte_valid = 1'b1;
      ip_eof        = (i == n - 1) && (mode == 0 || mode == 3);
      ip_err        = (i == n - 1) && (mode == 3);
      idle(3);
    end
    if (mode == 1) begin
      @(negedge clk);
      ip_eof = 1'b1;
      idle(1);
    end
    idle(3);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ip_data_in    = '0;
    ip_byte_valid = 1'b0;
    ip_eof        = 1'b0;
    ip_err        = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({udp_data_out, udp_byte_valid, udp_eof, udp_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_data_flags: got %h want 0", {udp_data_out, udp_byte_valid, udp_eof, udp_err});
    end
    checks++;
    if ({udp_src_port, udp_payload_len} !== 32'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", {udp_src_port, udp_payload_len});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  // Good datagram: dst 5000, len 28, 20 payload bytes, eof on the last
  task automatic test_good(input logic [15:0] src, input string tag);
    build(src, 16'd5000, 16'd28, 20);
    mark();
    send(28, 0);
    checks++;
    if (out_q.size() - base_out !== 20) begin
      errors++;
      $display("FAIL %s_count: got %0d want 20", tag, out_q.size() - base_out);
    end
    for (int i = 0; i < 20; i++) begin
      if (base_out + i < out_q.size()) begin
        checks++;
        if (out_q[base_out + i] !== pay[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %h want %h", tag, i, out_q[base_out + i], pay[i]);
        end
      end
    end
    checks++;
    if (n_eof - base_eof !== 1 || n_err - base_err !== 0) begin
      errors++;
      $display("FAIL %s_eof_err: got eof=%0d err=%0d want eof=1 err=0", tag, n_eof - base_eof, n_err - base_err);
    end
    checks++;
    if (eof_with_byte !== 1'b1) begin
      errors++;
      $display("FAIL %s_eof_on_last: got %b want 1", tag, eof_with_byte);
    end
    checks++;
    if (udp_payload_len !== 16'd20 || udp_src_port !== src) begin
      errors++;
      $display("FAIL %s_fields: got len=%0d src=%0d want len=20 src=%0d", tag, udp_payload_len, udp_src_port, src);
    end
  endtask

  task automatic test_port_mismatch();
    build(16'd777, 16'd5001, 16'd28, 20);
    mark();
    send(28, 0);
    checks++;
    if (out_q.size() - base_out !== 0 || n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL port_mismatch: got bytes=%0d err=%0d eof=%0d want 0/1/0",
               out_q.size() - base_out, n_err - base_err, n_eof - base_eof);
    end
    checks++;
    if (udp_src_port !== 16'd1111 || udp_payload_len !== 16'd20) begin
      errors++;
      $display("FAIL port_mismatch_hold: got src=%0d len=%0d want 1111/20", udp_src_port, udp_payload_len);
    end
  endtask

  task automatic test_padding();
    build(16'd2222, 16'd5000, 16'd18, 16);
    mark();
    send(24, 0);
    checks++;
    if (out_q.size() - base_out !== 10) begin
      errors++;
      $display("FAIL pad_count: got %0d want 10", out_q.size() - base_out);
    end
    for (int i = 0; i < 10; i++) begin
      if (base_out + i < out_q.size()) begin
        checks++;
        if (out_q[base_out + i] !== pay[i]) begin
          errors++;
          $display("FAIL pad_byte%0d: got %h want %h", i, out_q[base_out + i], pay[i]);
        end
      end
    end
    checks++;
    if (n_eof - base_eof !== 1 || n_err - base_err !== 0 || eof_with_byte !== 1'b0) begin
      errors++;
      $display("FAIL pad_eof: got eof=%0d err=%0d with_byte=%b want 1/0/0",
               n_eof - base_eof, n_err - base_err, eof_with_byte);
    end
    checks++;
    if (udp_payload_len !== 16'd10) begin
      errors++;
      $display("FAIL pad_len: got %0d want 10", udp_payload_len);
    end
  endtask

  task automatic test_short();
    build(16'd3333, 16'd5000, 16'd38, 20);
    mark();
    send(28, 0);
    checks++;
    if (out_q.size() - base_out !== 20 || n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL short: got bytes=%0d err=%0d eof=%0d want 20/1/0",
               out_q.size() - base_out, n_err - base_err, n_eof - base_eof);
    end
    build(16'd4444, 16'd5000, 16'd4, 4);
    mark();
    send(12, 0);
    checks++;
    if (out_q.size() - base_out !== 0 || n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL len_lt8: got bytes=%0d err=%0d eof=%0d want 0/1/0",
               out_q.size() - base_out, n_err - base_err, n_eof - base_eof);
    end
    build(16'd4545, 16'd5000, 16'd28, 0);
    mark();
    send(5, 0);
    checks++;
    if (n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL runt_hdr: got err=%0d eof=%0d want 1/0", n_err - base_err, n_eof - base_eof);
    end
  endtask

  task automatic test_abort();
    build(16'd5555, 16'd5000, 16'd28, 20);
    mark();
    send(13, 2);
    @(negedge clk);
    ip_err = 1'b1;
    idle(4);
    checks++;
    if (out_q.size() - base_out !== 5 || n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL abort: got bytes=%0d err=%0d eof=%0d want 5/1/0",
               out_q.size() - base_out, n_err - base_err, n_eof - base_eof);
    end
    test_good(16'd6666, "after_abort");
    build(16'd6767, 16'd5000, 16'd28, 20);
    mark();
    send(28, 3);
    checks++;
    if (out_q.size() - base_out !== 19 || n_err - base_err !== 1 || n_eof - base_eof !== 0) begin
      errors++;
      $display("FAIL err_and_eof: got bytes=%0d err=%0d eof=%0d want 19/1/0",
               out_q.size() - base_out, n_err - base_err, n_eof - base_eof);
    end
  endtask

  task automatic test_zero_len();
    build(16'd7777, 16'd5000, 16'd8, 0);
    mark();
    send(8, 1);
    checks++;
    if (out_q.size() - base_out !== 0 || n_eof - base_eof !== 1 || n_err - base_err !== 0) begin
      errors++;
      $display("FAIL zero_len: got bytes=%0d eof=%0d err=%0d want 0/1/0",
               out_q.size() - base_out, n_eof - base_eof, n_err - base_err);
    end
    checks++;
    if (udp_payload_len !== 16'd0 || udp_src_port !== 16'd7777) begin
      errors++;
      $display("FAIL zero_len_fields: got len=%0d src=%0d want 0/7777", udp_payload_len, udp_src_port);
    end
    build(16'd7878, 16'd5000, 16'd8, 0);
    mark();
    send(8, 0);
    checks++;
    if (n_eof - base_eof !== 1 || n_err - base_err !== 0) begin
      errors++;
      $display("FAIL zero_len_eof_on_hdr: got eof=%0d err=%0d want 1/0", n_eof - base_eof, n_err - base_err);
    end
  endtask

  task automatic test_idle_events();
    mark();
    @(negedge clk);
    ip_eof = 1'b1;
    idle(1);
    @(negedge clk);
    ip_err = 1'b1;
    idle(4);
    checks++;
    if (n_eof - base_eof !== 0 || n_err - base_err !== 0) begin
      errors++;
      $display("FAIL idle_events: got eof=%0d err=%0d want 0/0", n_eof - base_eof, n_err - base_err);
    end
  endtask

  task automatic test_reset_mid();
    build(16'd8888, 16'd5000, 16'd28, 20);
    send(13, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({udp_data_out, udp_byte_valid, udp_eof, udp_err, udp_src_port, udp_payload_len} !== 43'd0) begin
      errors++;
      $display("FAIL reset_mid: got src=%0d len=%0d valid=%b want all 0", udp_src_port, udp_payload_len, udp_byte_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark();
    idle(3);
    @(negedge clk);
    ip_eof = 1'b1;
    idle(4);
    checks++;
    if (n_eof - base_eof !== 0 || n_err - base_err !== 0 || out_q.size() - base_out !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got eof=%0d err=%0d bytes=%0d want 0/0/0",
               n_eof - base_eof, n_err - base_err, out_q.size() - base_out);
    end
    test_good(16'd9999, "after_reset");
  endtask

  initial begin
    test_reset();
    test_good(16'd1111, "good");
    test_port_mismatch();
    test_padding();
    test_short();
    test_abort();
    test_zero_len();
    test_idle_events();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
